// File: rtl/carfield_eoc_pkg.sv
// Shared types for the multi-domain end-of-computation collector.
// Default widths here match the collector's default NumChan/CodeWidth parameters.
package carfield_eoc_pkg;

   localparam int unsigned NUM_CHAN   = 4;
   localparam int unsigned CODE_WIDTH = 31;
   localparam int unsigned FIRST_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

   typedef enum logic [1:0] {
      EOC_ALL     = 2'd0,
      EOC_ANY     = 2'd1,
      EOC_ORDERED = 2'd2,
      EOC_RSVD    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [CODE_WIDTH-1:0] code;
      logic [FIRST_W-1:0]    first;
      logic [NUM_CHAN-1:0]   mask;
      logic                  err;
      logic                  timeout;
   } eoc_res_t;

   localparam logic [CODE_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/carfield_eoc_if.sv
// Control, per-channel EOC and aggregated result signals of the collector.
// Signal suffixes are relative to the collector (slave modport).
interface carfield_eoc_if #(
   parameter int unsigned NumChan   = 4,
   parameter int unsigned CodeWidth = 31
);
   localparam int unsigned FirstW = (NumChan > 1) ? $clog2(NumChan) : 1;

   logic                         start_i;
   logic [1:0]                   mode_i;
   logic [NumChan-1:0]           chan_en_i;
   logic [NumChan-1:0]           eoc_valid_i;
   logic [NumChan*CodeWidth-1:0] eoc_code_i;
   logic [NumChan-1:0]           eoc_ready_o;
   logic                         res_valid_o;
   logic                         res_ready_i;
   logic [CodeWidth-1:0]         res_code_o;
   logic [FirstW-1:0]            res_first_o;
   logic [NumChan-1:0]           res_mask_o;
   logic                         res_err_o;
   logic                         res_timeout_o;
   logic                         busy_o;

   modport slave (
      input  start_i, mode_i, chan_en_i, eoc_valid_i, eoc_code_i, res_ready_i,
      output eoc_ready_o, res_valid_o, res_code_o, res_first_o, res_mask_o,
             res_err_o, res_timeout_o, busy_o
   );

   modport master (
      output start_i, mode_i, chan_en_i, eoc_valid_i, eoc_code_i, res_ready_i,
      input  eoc_ready_o, res_valid_o, res_code_o, res_first_o, res_mask_o,
             res_err_o, res_timeout_o, busy_o
   );

endinterface

// File: rtl/carfield_eoc_chan.sv
// One EOC source channel: ready while armed and not yet captured, then holds
// its done flag and exit code until the next run is armed.
module carfield_eoc_chan #(
   parameter int unsigned CodeWidth = 31
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 arm_i,
   input  logic                 en_i,
   input  logic                 valid_i,
   input  logic [CodeWidth-1:0] code_i,
   output logic                 ready_o,
   output logic                 capture_o,
   output logic                 done_o,
   output logic [CodeWidth-1:0] code_o
);

   logic                 done_q, done_d;
   logic [CodeWidth-1:0] code_q, code_d;

   assign ready_o   = arm_i & en_i & ~done_q;
   assign capture_o = ready_o & valid_i;
   assign done_o    = done_q;
   assign code_o    = code_q;

   always_comb begin
      // NOTE: defaults first so every path assigns the next state and no latch is inferred.
      done_d = done_q;
      code_d = code_q;
      if (clear_i) begin
         done_d = 1'b0;
         code_d = '0;
      end else if (capture_o) begin
         done_d = 1'b1;
         code_d = code_i;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: the code register is reset too; the result encoder reads it and must never see X.
      if (rst_i) begin
         done_q <= 1'b0;
         code_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         done_q <= done_d;
         code_q <= code_d;
      end
   end

endmodule

// File: rtl/carfield_eoc_collector.sv
// Multi-domain EOC collector: arms on start, captures per-channel exit codes
// in ALL/ANY/ORDERED mode and presents one result. Watchdog: CARFIELD_EOC_TIMEOUT_EN.
module carfield_eoc_collector
   import carfield_eoc_pkg::*;
#(
   parameter int unsigned NumChan    = NUM_CHAN,
   parameter int unsigned CodeWidth  = CODE_WIDTH,
   parameter int unsigned TimeoutCyc = 2**20
) (
   input logic           clk_i,
   input logic           rst_i,
   carfield_eoc_if.slave eoc
);

   localparam int unsigned FirstW = (NumChan > 1) ? $clog2(NumChan) : 1;

   state_e               state_q, state_d;
   mode_e                mode_q, mode_d;
   logic [NumChan-1:0]   en_q, en_d;
   logic [FirstW-1:0]    first_q, first_d;
   logic                 err_q, err_d;
   logic                 tmo_q, tmo_d;

   logic                 arm_run, in_wait, tmo_hit;
   logic [NumChan-1:0]   cap, done, pending;
   logic [CodeWidth-1:0] code_ch [NumChan];
   logic [FirstW-1:0]    cap_low;
   logic                 order_err, gap, complete, err_now;
   eoc_res_t             res_s;

   assign arm_run = (state_q == ST_IDLE) && eoc.start_i;
   assign in_wait = (state_q == ST_WAIT);

   for (genvar g = 0; g < NumChan; g++) begin : g_chan
      carfield_eoc_chan #(.CodeWidth(CodeWidth)) u_chan (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .clear_i   (arm_run),
         .arm_i     (in_wait),
         .en_i      (en_q[g]),
         .valid_i   (eoc.eoc_valid_i[g]),
         .code_i    (eoc.eoc_code_i[g*CodeWidth +: CodeWidth]),
         .ready_o   (eoc.eoc_ready_o[g]),
         .capture_o (cap[g]),
         .done_o    (done[g]),
         .code_o    (code_ch[g])
      );
   end

   // Ordering: a capture is illegal if a lower enabled channel is still pending and not captured now.
   always_comb begin
      pending   = en_q & ~done;
      cap_low   = '0;
      gap       = 1'b0;
      order_err = 1'b0;
      for (int i = NumChan - 1; i >= 0; i--) begin
         if (cap[i]) cap_low = FirstW'(i);
      end
      for (int i = 0; i < NumChan; i++) begin
         if (pending[i] && !cap[i]) gap = 1'b1;
         else if (cap[i] && gap)    order_err = 1'b1;
      end
      unique case (mode_q)
         EOC_ALL:     complete = ((done | cap) == en_q);
         EOC_ANY:     complete = |cap;
         EOC_ORDERED: complete = ((done | cap) == en_q) || order_err;
         default:     complete = 1'b1;
      endcase
      if (en_q == '0) complete = 1'b1;
      err_now = (mode_q == EOC_RSVD) || ((mode_q == EOC_ORDERED) && order_err);
   end

`ifdef CARFIELD_EOC_TIMEOUT_EN
   localparam int unsigned CntW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || arm_run) cnt_q <= '0;
      else if (in_wait)     cnt_q <= cnt_q + 1'b1;
   end

   assign tmo_hit = in_wait && (cnt_q == CntW'(TimeoutCyc - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      en_d    = en_q;
      first_d = first_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         ST_IDLE: if (eoc.start_i) begin
            state_d = ST_WAIT;
            mode_d  = mode_e'(eoc.mode_i);
            en_d    = eoc.chan_en_i;
            first_d = '0;
            err_d   = 1'b0;
            tmo_d   = 1'b0;
         end
         ST_WAIT: begin
            if ((|cap) && (done == '0)) first_d = cap_low;
            if (complete) begin
               state_d = ST_DONE;
               err_d   = err_now;
            end else if (tmo_hit) begin
               state_d = ST_DONE;
               tmo_d   = 1'b1;
            end
         end
         ST_DONE: if (eoc.res_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         mode_q  <= EOC_ALL;
         en_q    <= '0;
         first_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         en_q    <= en_d;
         first_q <= first_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   // Result is built from held registers only, so it stays stable throughout DONE.
   always_comb begin
      res_s = '0;
      if (state_q == ST_DONE) begin
         res_s.mask    = done;
         res_s.first   = first_q;
         res_s.err     = err_q;
         res_s.timeout = tmo_q;
         for (int i = NumChan - 1; i >= 0; i--) begin
            if (done[i] && (code_ch[i] != '0)) res_s.code = code_ch[i];
         end
         if (err_q || tmo_q) res_s.code = ALL_ONES;
      end
   end

   assign eoc.res_valid_o   = (state_q == ST_DONE);
   assign eoc.res_code_o    = res_s.code;
   assign eoc.res_first_o   = res_s.first;
   assign eoc.res_mask_o    = res_s.mask;
   assign eoc.res_err_o     = res_s.err;
   assign eoc.res_timeout_o = res_s.timeout;
   assign eoc.busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_carfield_eoc_collector.sv
// Self-checking bench for carfield_eoc_collector: directed scenarios plus
// randomized runs scored against a cycle-level behavioural model.
module tb_carfield_eoc_collector;

   localparam int N  = 4;
   localparam int CW = 31;
`ifdef CARFIELD_EOC_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int TMO_CYC = 16;

   typedef struct packed {
      logic [N-1:0]    v;
      logic [N*CW-1:0] c;
   } step_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   carfield_eoc_if #(.NumChan(N), .CodeWidth(CW)) bus ();

   carfield_eoc_collector #(.NumChan(N), .CodeWidth(CW), .TimeoutCyc(TMO_CYC)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .eoc   (bus)
   );

   int    total = 0;
   int    bad   = 0;
   step_t steps[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic step_t mk(input logic [N-1:0] v, input int c0, input int c1,
                                input int c2, input int c3);
      step_t s;
      s.v = v;
      s.c = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
      return s;
   endfunction

   task automatic arm(input logic [1:0] mode, input logic [N-1:0] en);
      bus.start_i   = 1'b1;
      bus.mode_i    = mode;
      bus.chan_en_i = en;
      tick();
      bus.start_i   = 1'b0;
      bus.mode_i    = 2'($urandom);
      bus.chan_en_i = N'($urandom);
   endtask

   // Plays queued steps (then all-valid or idle) and scores the run against the rules.
   task automatic run_case(input string nm, input logic [1:0] mode, input logic [N-1:0] en,
                           input bit fill, input int hold);
      logic [N-1:0]  cap, rdy, acc, pend;
      logic [CW-1:0] code [N];
      logic [CW-1:0] exp_code;
      int            first, wcnt;
      bit            fin, err, tmo, ooo;
      step_t         s;
      cap = '0; first = -1; wcnt = 0; fin = 0; err = 0; tmo = 0;
      for (int i = 0; i < N; i++) code[i] = '0;
      arm(mode, en);
      while (!fin) begin
         if (steps.size() > 0) s = steps.pop_front();
         else s = mk(fill ? {N{1'b1}} : {N{1'b0}}, 0, 0, 0, 0);
         bus.eoc_valid_i = s.v;
         bus.eoc_code_i  = s.c;
         rdy = en & ~cap;
         check({nm, ":ready"}, 64'(bus.eoc_ready_o), 64'(rdy));
         check({nm, ":busy"}, 64'(bus.busy_o), 64'd1);
         check({nm, ":early_valid"}, 64'(bus.res_valid_o), 64'd0);
         acc  = s.v & rdy;
         pend = en & ~cap;
         ooo  = 0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < i; j++)
               if (acc[i] && pend[j] && !acc[j]) ooo = 1;
         if (first < 0)
            for (int i = N - 1; i >= 0; i--) if (acc[i]) first = i;
         for (int i = 0; i < N; i++) if (acc[i]) code[i] = s.c[i*CW +: CW];
         cap = cap | acc;
         case (mode)
            2'd0: fin = (cap == en);
            2'd1: fin = (acc != 0);
            2'd2: begin fin = (cap == en) || ooo; err = ooo; end
            default: begin fin = 1; err = 1; end
         endcase
         if (en == 0) fin = 1;
         if (!fin && TMO_EN && wcnt == TMO_CYC - 1) begin fin = 1; tmo = 1; end
         wcnt++;
         if (!fin && wcnt > 200) begin
            check({nm, ":cycle_budget"}, 64'd0, 64'd1);
            fin = 1;
         end
         tick();
      end
      exp_code = '0;
      for (int i = N - 1; i >= 0; i--) if (cap[i] && code[i] != 0) exp_code = code[i];
      if (err || tmo) exp_code = '1;
      for (int h = 0; h <= hold; h++) begin
         bus.eoc_valid_i = N'($urandom);
         check({nm, ":res_valid"}, 64'(bus.res_valid_o), 64'd1);
         check({nm, ":res_code"}, 64'(bus.res_code_o), 64'(exp_code));
         check({nm, ":res_first"}, 64'(bus.res_first_o), (first < 0) ? 64'd0 : 64'(first));
         check({nm, ":res_mask"}, 64'(bus.res_mask_o), 64'(cap));
         check({nm, ":res_err"}, 64'(bus.res_err_o), 64'(err));
         check({nm, ":res_timeout"}, 64'(bus.res_timeout_o), 64'(tmo));
         check({nm, ":done_ready"}, 64'(bus.eoc_ready_o), 64'd0);
         if (h == hold) begin
            bus.res_ready_i = 1'b1;
            bus.start_i     = 1'b1;
         end
         tick();
      end
      bus.res_ready_i = 1'b0;
      bus.start_i     = 1'b0;
      bus.eoc_valid_i = '0;
      check({nm, ":released"}, 64'(bus.res_valid_o), 64'd0);
      check({nm, ":start_in_handshake_ignored"}, 64'(bus.busy_o), 64'd0);
   endtask

   initial begin
      step_t s;
      bus.start_i     = 1'b0;
      bus.mode_i      = 2'd0;
      bus.chan_en_i   = '0;
      bus.eoc_valid_i = '0;
      bus.eoc_code_i  = '0;
      bus.res_ready_i = 1'b0;
      repeat (3) tick();
      check("reset:busy", 64'(bus.busy_o), 64'd0);
      check("reset:valid", 64'(bus.res_valid_o), 64'd0);
      check("reset:ready", 64'(bus.eoc_ready_o), 64'd0);
      check("reset:code", 64'(bus.res_code_o), 64'd0);
      check("reset:mask", 64'(bus.res_mask_o), 64'd0);
      rst = 1'b0;
      tick();

      // ALL, channels finish 2,0,3,1 with zero codes
      steps.push_back(mk(4'b0100, 0, 0, 0, 0));
      steps.push_back(mk(4'b0001, 0, 0, 0, 0));
      steps.push_back(mk(4'b1000, 0, 0, 0, 0));
      steps.push_back(mk(4'b0010, 0, 0, 0, 0));
      run_case("all_2031", 2'd0, 4'b1111, 1'b0, 1);

      // ANY: ch2 code 5 wins, later valids see ready low
      steps.push_back(mk(4'b0100, 0, 0, 5, 0));
      run_case("any_ch2", 2'd1, 4'b0110, 1'b0, 3);

      // ORDERED: ch3 overtakes ch1
      steps.push_back(mk(4'b0001, 0, 0, 0, 0));
      steps.push_back(mk(4'b1000, 0, 0, 0, 0));
      run_case("ordered_err", 2'd2, 4'b1011, 1'b0, 0);

      // simultaneous captures, result held for 5 stalled cycles
      steps.push_back(mk(4'b1010, 0, 7, 0, 9));
      run_case("simul_hold", 2'd0, 4'b1010, 1'b0, 5);

      if (TMO_EN) begin
         run_case("timeout", 2'd0, 4'b0001, 1'b0, 1);
      end else begin
         arm(2'd0, 4'b0001);
         repeat (1000) tick();
         check("no_timeout:busy", 64'(bus.busy_o), 64'd1);
         check("no_timeout:valid", 64'(bus.res_valid_o), 64'd0);
         rst = 1'b1;
         tick();
         rst = 1'b0;
         check("no_timeout:reset_idle", 64'(bus.busy_o), 64'd0);
      end

      // reset mid-WAIT after two captures, then a fresh run starts with nothing captured
      arm(2'd0, 4'b1111);
      bus.eoc_valid_i = 4'b0011;
      tick();
      bus.eoc_valid_i = '0;
      check("midrst:busy_before", 64'(bus.busy_o), 64'd1);
      check("midrst:ready_before", 64'(bus.eoc_ready_o), 64'(4'b1100));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst:busy_after", 64'(bus.busy_o), 64'd0);
      check("midrst:ready_after", 64'(bus.eoc_ready_o), 64'd0);
      steps.push_back(mk(4'b0100, 0, 0, 3, 0));
      run_case("after_rst", 2'd0, 4'b1111, 1'b1, 0);

      run_case("mode_rsvd", 2'd3, 4'b1111, 1'b0, 0);
      run_case("en_zero_all", 2'd0, 4'b0000, 1'b1, 0);
      run_case("en_zero_any", 2'd1, 4'b0000, 1'b1, 0);

      for (int k = 0; k < 40; k++) begin
         int nst;
         nst = $urandom_range(0, 8);
         for (int t = 0; t < nst; t++) begin
            s.v = N'($urandom);
            s.c = '0;
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 2) == 0) s.c[i*CW +: CW] = CW'($urandom_range(1, 100));
            steps.push_back(s);
         end
         run_case($sformatf("rand%0d", k), 2'($urandom_range(0, 2)), N'($urandom), 1'b1,
                  $urandom_range(0, 3));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
